// File: rtl/pfd_sync_detector.sv
// Three-state phase-frequency detector comparing rising edges of link and vco on clk.
// Define PFD_INPUT_SYNC_EN to add a 2-flop synchronizer on each input (2 cycles extra latency).
module pfd_sync_detector #(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link,
    input  logic       vco,
    output logic       up,
    output logic       dn,
    output logic       upb,
    output logic       dnb,
    output logic [1:0] setting
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DN   = 2'd2;

    localparam int IN_L = 0;
    localparam int IN_V = 1;

    localparam logic             TMO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] in_raw;
    logic [1:0] rise;

    assign in_raw = {vco, link};

    // Per-input sampling path: optional synchronizer, then a history flop for edge detection.
    // A history of 0 out of reset makes an already-high input count as a fresh edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            logic smp;
            logic hist_reg;
`ifdef PFD_INPUT_SYNC_EN
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= in_raw[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign smp = sync_reg;
`else
            assign smp = in_raw[gi];
`endif
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_reg <= 1'b0;
                end else begin
                    hist_reg <= smp;
                end
            end

            assign rise[gi] = smp & ~hist_reg;
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    logic up_reg;
    logic dn_reg;
    logic upb_reg;
    logic dnb_reg;
    logic act_reg;
    logic dir_reg;
    logic dir_next;

    assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : (cnt_reg + CNT_ONE);
    assign timeout_hit = TMO_EN && (cnt_inc == TMO_VAL);

    // Simultaneous edges carry no phase error, so IDLE ignores them; inside a pulse
    // only the lagging input's edge matters.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (rise[IN_L] && !rise[IN_V]) begin
                    state_next = ST_UP;
                end else if (rise[IN_V] && !rise[IN_L]) begin
                    state_next = ST_DN;
                end
            end
            ST_UP: begin
                if (timeout_hit || rise[IN_V]) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DN: begin
                if (timeout_hit || rise[IN_L]) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_next = '0;
        if (state_next != ST_IDLE && state_reg != ST_IDLE) begin
            cnt_next = cnt_inc;
        end
    end

    // Direction survives the return to IDLE so it can be read as the pulse ends.
    always_comb begin
        dir_next = dir_reg;
        if (state_reg == ST_IDLE && state_next == ST_DN) begin
            dir_next = 1'b1;
        end else if (state_reg == ST_IDLE && state_next == ST_UP) begin
            dir_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            up_reg    <= 1'b0;
            dn_reg    <= 1'b0;
            upb_reg   <= 1'b1;
            dnb_reg   <= 1'b1;
            act_reg   <= 1'b0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            up_reg    <= (state_next == ST_UP);
            dn_reg    <= (state_next == ST_DN);
            upb_reg   <= (state_next != ST_UP);
            dnb_reg   <= (state_next != ST_DN);
            act_reg   <= (state_next != ST_IDLE);
            dir_reg   <= dir_next;
        end
    end

    assign up      = up_reg;
    assign dn      = dn_reg;
    assign upb     = upb_reg;
    assign dnb     = dnb_reg;
    assign setting = {dir_reg, act_reg};

endmodule

// File: tb/tb_pfd_sync_detector.sv
// Self-checking bench for pfd_sync_detector: directed vector table, timeout and
// asynchronous-reset sequences, then random stimulus against a behavioural model.
module tb_pfd_sync_detector;

`ifdef PFD_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       link;
    logic       vco;
    logic       up_o  [2];
    logic       dn_o  [2];
    logic       upb_o [2];
    logic       dnb_o [2];
    logic [1:0] set_o [2];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pfd_sync_detector dut0 (
        .clk(clk), .rst(rst), .link(link), .vco(vco),
        .up(up_o[0]), .dn(dn_o[0]), .upb(upb_o[0]), .dnb(dnb_o[0]), .setting(set_o[0])
    );

    pfd_sync_detector #(.TIMEOUT_CYCLES(5), .CNT_W(8)) dut5 (
        .clk(clk), .rst(rst), .link(link), .vco(vco),
        .up(up_o[1]), .dn(dn_o[1]), .upb(upb_o[1]), .dnb(dnb_o[1]), .setting(set_o[1])
    );

    typedef struct {
        logic       link;
        logic       vco;
        logic       up;
        logic       dn;
        logic [1:0] setting;
    } vec_t;

    vec_t tab[$];

    function automatic void add(logic l, logic v, logic u, logic d, logic [1:0] s);
        vec_t e;
        e.link = l; e.vco = v; e.up = u; e.dn = d; e.setting = s;
        tab.push_back(e);
    endfunction

    function automatic void addn(int n, logic l, logic v, logic u, logic d, logic [1:0] s);
        for (int i = 0; i < n; i++) add(l, v, u, d, s);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(int i, string tag, logic u, logic d, logic [1:0] s);
        chk({tag, ".up"},      int'(up_o[i]),  int'(u));
        chk({tag, ".dn"},      int'(dn_o[i]),  int'(d));
        chk({tag, ".upb"},     int'(upb_o[i]), int'(!u));
        chk({tag, ".dnb"},     int'(dnb_o[i]), int'(!d));
        chk({tag, ".setting"}, int'(set_o[i]), int'(s));
    endtask

    // Behavioural model: a pulse starts at the first unmatched rising edge and lasts until
    // the other input rises (or the timeout expires); the input pipeline is a plain delay queue.
    int tmo[2] = '{0, 5};
    int m_mode[2];   // 0 = no pulse, 1 = reference leads, 2 = vco leads
    int m_age[2];
    bit m_dir[2];
    bit m_pl, m_pv;
    bit q_l[$];
    bit q_v[$];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_age[k] = 0; m_dir[k] = 0;
        end
        m_pl = 0; m_pv = 0;
        q_l.delete(); q_v.delete();
    endfunction

    function automatic void model_step(bit l, bit v);
        bit el, ev, rl, rv;
        q_l.push_back(l);
        q_v.push_back(v);
        el = (q_l.size() > LAT) ? q_l.pop_front() : 1'b0;
        ev = (q_v.size() > LAT) ? q_v.pop_front() : 1'b0;
        rl = el && !m_pl;
        rv = ev && !m_pv;
        m_pl = el;
        m_pv = ev;
        for (int k = 0; k < 2; k++) begin
            if (m_mode[k] == 0) begin
                if (rl && !rv) begin m_mode[k] = 1; m_age[k] = 0; m_dir[k] = 0; end
                else if (rv && !rl) begin m_mode[k] = 2; m_age[k] = 0; m_dir[k] = 1; end
            end else begin
                m_age[k]++;
                if (tmo[k] > 0 && m_age[k] == tmo[k]) m_mode[k] = 0;
                else if (m_mode[k] == 1 && rv) m_mode[k] = 0;
                else if (m_mode[k] == 2 && rl) m_mode[k] = 0;
            end
        end
    endfunction

    task automatic cycle(bit l, bit v);
        @(negedge clk);
        link = l;
        vco  = v;
        @(posedge clk);
        model_step(l, v);
        #1;
    endtask

    task automatic reset_quiet();
        @(negedge clk);
        rst = 1'b1; link = 1'b0; vco = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        int cnt5;
        int first;
        bit rl, rv;

        rst = 1'b1; link = 1'b0; vco = 1'b0;

        // Reset held with random inputs: outputs must stay at reset values.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            link = 1'($urandom); vco = 1'($urandom);
            @(posedge clk);
            #1;
            $display("reset cycle %0d link=%b vco=%b", i, link, vco);
            check_out(0, "rst0", 1'b0, 1'b0, 2'b00);
            check_out(1, "rst5", 1'b0, 1'b0, 2'b00);
        end
        @(negedge clk);
        link = 1'b0; vco = 1'b0;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            $display("post-reset cycle %0d", i);
            check_out(0, "rel0", 1'b0, 1'b0, 2'b00);
        end

        // Directed vectors, expectations written for zero input latency.
        addn(2, 0, 0, 0, 0, 2'b00);
        add(1, 0, 1, 0, 2'b01);                 // reference leads by 10
        addn(9, 1, 0, 1, 0, 2'b01);
        add(1, 1, 0, 0, 2'b00);
        add(0, 0, 0, 0, 2'b00);
        add(0, 1, 0, 1, 2'b11);                 // vco leads by 7
        addn(6, 0, 1, 0, 1, 2'b11);
        add(1, 1, 0, 0, 2'b10);
        add(0, 0, 0, 0, 2'b10);
        add(1, 1, 0, 0, 2'b10);                 // simultaneous in idle
        add(0, 0, 0, 0, 2'b10);
        add(1, 0, 1, 0, 2'b01);                 // second link edge inside UP
        add(0, 0, 1, 0, 2'b01);
        add(1, 0, 1, 0, 2'b01);
        add(1, 0, 1, 0, 2'b01);
        add(1, 1, 0, 0, 2'b00);
        add(0, 0, 0, 0, 2'b00);
        add(0, 1, 0, 1, 2'b11);                 // simultaneous edges end DN
        add(0, 0, 0, 1, 2'b11);
        add(1, 1, 0, 0, 2'b10);
        add(0, 0, 0, 0, 2'b10);
        add(1, 0, 1, 0, 2'b01);                 // simultaneous edges end UP
        add(0, 0, 1, 0, 2'b01);
        add(1, 1, 0, 0, 2'b00);
        addn(3, 0, 0, 0, 0, 2'b00);

        for (int i = 0; i < tab.size(); i++) begin
            cycle(tab[i].link, tab[i].vco);
            $display("vec %0d link=%b vco=%b up=%b dn=%b setting=%b",
                     i, tab[i].link, tab[i].vco, up_o[0], dn_o[0], set_o[0]);
            if (i >= LAT) begin
                check_out(0, $sformatf("vec%0d", i - LAT),
                          tab[i - LAT].up, tab[i - LAT].dn, tab[i - LAT].setting);
            end
        end

        // Timeout: link rises and vco never does.
        reset_quiet();
        cnt5 = 0;
        first = -1;
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 1'b0);
            $display("timeout cycle %0d up0=%b up5=%b", c, up_o[0], up_o[1]);
            if (up_o[1]) begin
                if (first < 0) first = c;
                cnt5++;
            end
        end
        chk("to.width", cnt5, 5);
        chk("to.start", first, LAT);
        chk("to.dut0_up", int'(up_o[0]), 1);
        check_out(1, "to.after", 1'b0, 1'b0, 2'b00);

        // vco edge: ends dut0's UP pulse, starts a DN pulse on dut5; then reset mid-pulse.
        for (int c = 0; c <= LAT; c++) cycle(1'b0, 1'b1);
        $display("pre-reset up0=%b dn5=%b set5=%b", up_o[0], dn_o[1], set_o[1]);
        check_out(0, "mid.dut0", 1'b0, 1'b0, 2'b00);
        check_out(1, "mid.dut5", 1'b0, 1'b1, 2'b11);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset applied set5=%b", set_o[1]);
        check_out(1, "arst5", 1'b0, 1'b0, 2'b00);
        check_out(0, "arst0", 1'b0, 1'b0, 2'b00);

        // Random stimulus against the model, inputs possibly high at reset release.
        @(posedge clk);
        #1;
        rl = 1'($urandom);
        rv = 1'($urandom);
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(3) == 0) rl = !rl;
            if ($urandom_range(3) == 0) rv = !rv;
            cycle(rl, rv);
            $display("rnd %0d link=%b vco=%b up=%b%b dn=%b%b set=%b/%b",
                     n, rl, rv, up_o[0], up_o[1], dn_o[0], dn_o[1], set_o[0], set_o[1]);
            for (int k = 0; k < 2; k++) begin
                check_out(k, $sformatf("rnd%0d.d%0d", n, k),
                          logic'(m_mode[k] == 1), logic'(m_mode[k] == 2),
                          {logic'(m_dir[k]), logic'(m_mode[k] != 0)});
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
